// File: rtl/fp32_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp32_tx_scheduler
// Description : Round-robin arbiter that shares one byte-wide UART TX path
//               between NUM_REQ FP32 producers. Each granted word is sent
//               as a 6-byte frame: SYNC, ID, B0..B3 (LSB first), followed
//               by an optional idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_tx_scheduler #(
    parameter int         NUM_REQ    = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         GAP_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [32*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic                  byte_valid_o,
    output logic [7:0]            byte_data_o,
    input  logic                  byte_ready_i,
    output logic                  busy_o,
    output logic [15:0]           frames_sent_o
);

    localparam int IDW = 2;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GCW-1:0] GAP_LOAD = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_ID   = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    // The pointer doubles as the frame ID: it is loaded with the granted
    // index and does not move again until the next grant.
    logic [2:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [31:0]    word_q, word_d;
    logic [1:0]     k_q, k_d;
    logic [GCW-1:0] gap_q, gap_d;
    logic [15:0]    frames_sent_q, frames_sent_d;
    logic           busy_q;

    logic           grant_found;
    logic           grant_go;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand_idx;
    logic [31:0]    grant_word;

    // Round-robin search from ptr+1 upward; walking downward lets the
    // nearest candidate overwrite farther ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand_idx = IDW'((int'(ptr_q) + i) % NUM_REQ);
            if (req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A grant is suppressed while reset is asserted so a requester never
    // sees an accept that the FSM then drops.
    assign grant_go = (state_q == ST_IDLE) && grant_found && !rst_i;

    // Combinational one-hot accept so valid&ready completes in one cycle.
    always_comb begin
        req_ready_o = '0;
        if (grant_go) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Select the granted requester's word for capture.
    always_comb begin
        grant_word = '0;
        for (int g = 0; g < NUM_REQ; g++) begin
            if (grant_idx == IDW'(g)) begin
                grant_word = req_data_i[32*g +: 32];
            end
        end
    end

    // Frame sequencing: next-state, byte index, gap counter, frame count.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        word_d        = word_q;
        k_d           = k_q;
        gap_d         = gap_q;
        frames_sent_d = frames_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_go) begin
                    state_d = ST_SYNC;
                    ptr_d   = grant_idx;
                    word_d  = grant_word;
                end
            end
            ST_SYNC: begin
                if (byte_ready_i) state_d = ST_ID;
            end
            ST_ID: begin
                if (byte_ready_i) begin
                    state_d = ST_DATA;
                    k_d     = 2'd0;
                end
            end
            ST_DATA: begin
                if (byte_ready_i) begin
                    if (k_q == 2'd3) begin
                        frames_sent_d = frames_sent_q + 16'd1;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte presented to the UART is a pure decode of the held state, so it
    // stays stable for as long as byte_ready_i is low.
    always_comb begin
        byte_valid_o = 1'b0;
        byte_data_o  = 8'h00;
        case (state_q)
            ST_SYNC: begin
                byte_valid_o = 1'b1;
                byte_data_o  = SYNC_BYTE;
            end
            ST_ID: begin
                byte_valid_o = 1'b1;
                byte_data_o  = {6'b0, ptr_q};
            end
            ST_DATA: begin
                byte_valid_o = 1'b1;
                case (k_q)
                    2'd0:    byte_data_o = word_q[7:0];
                    2'd1:    byte_data_o = word_q[15:8];
                    2'd2:    byte_data_o = word_q[23:16];
                    default: byte_data_o = word_q[31:24];
                endcase
            end
            default: ;
        endcase
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IDW'(NUM_REQ - 1);
            word_q        <= '0;
            k_q           <= '0;
            gap_q         <= '0;
            frames_sent_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            word_q        <= word_d;
            k_q           <= k_d;
            gap_q         <= gap_d;
            frames_sent_q <= frames_sent_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign busy_o        = busy_q;
    assign frames_sent_o = frames_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_tx_scheduler
// Description : Self-checking bench for fp32_tx_scheduler. Two instances
//               share stimulus: one with a 16-cycle gap, one with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_tx_scheduler;

    logic         clk;
    logic         rst_i;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic         byte_ready_i;
    logic         sel;

    logic [3:0]  rr_a, rr_b;
    logic        bv_a, bv_b;
    logic [7:0]  bd_a, bd_b;
    logic        bz_a, bz_b;
    logic [15:0] fs_a, fs_b;

    logic [3:0]  req_ready_o;
    logic        byte_valid_o;
    logic [7:0]  byte_data_o;
    logic        busy_o;
    logic [15:0] frames_sent_o;

    assign req_ready_o   = sel ? rr_b : rr_a;
    assign byte_valid_o  = sel ? bv_b : bv_a;
    assign byte_data_o   = sel ? bd_b : bd_a;
    assign busy_o        = sel ? bz_b : bz_a;
    assign frames_sent_o = sel ? fs_b : fs_a;

    fp32_tx_scheduler #(.NUM_REQ(4), .SYNC_BYTE(8'hA5), .GAP_CYCLES(16)) u_dut_g16 (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(rr_a), .byte_valid_o(bv_a), .byte_data_o(bd_a),
        .byte_ready_i(byte_ready_i), .busy_o(bz_a), .frames_sent_o(fs_a)
    );

    fp32_tx_scheduler #(.NUM_REQ(4), .SYNC_BYTE(8'hA5), .GAP_CYCLES(0)) u_dut_g0 (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(rr_b), .byte_valid_o(bv_b), .byte_data_o(bd_b),
        .byte_ready_i(byte_ready_i), .busy_o(bz_b), .frames_sent_o(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_frames;

    typedef struct {
        bit           rst_before;
        logic [3:0]   valid;
        logic [127:0] data;
        bit           keep;
        int           stall_b;
        int           stall_n;
        int           exp_g;
        logic [31:0]  exp_word;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i        = 1'b1;
        req_valid_i  = '0;
        byte_ready_i = 1'b1;
        @(negedge clk);
        rst_i      = 1'b0;
        exp_frames = '0;
        check("rst_ready", {28'h0, req_ready_o}, 32'h0);
        check("rst_valid", {31'h0, byte_valid_o}, 32'h0);
        check("rst_data", {24'h0, byte_data_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_frames", {16'h0, frames_sent_o}, 32'h0);
    endtask

    // Called at a negedge with the DUT in IDLE; runs one whole frame and the
    // following gap, returning at the negedge where the FSM is back in IDLE.
    task automatic run_frame(input logic [3:0] valid, input logic [127:0] data, input bit keep,
                             input int stall_b, input int stall_n, input int exp_g,
                             input logic [31:0] exp_word, input int exp_gap);
        int waitc, b, n, holes, cyc, gap;
        logic [7:0] exp_b [6];
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'(exp_g);
        exp_b[2] = exp_word[7:0];
        exp_b[3] = exp_word[15:8];
        exp_b[4] = exp_word[23:16];
        exp_b[5] = exp_word[31:24];
        req_valid_i  = valid;
        req_data_i   = data;
        byte_ready_i = 1'b1;
        #1;
        waitc = 0;
        while (req_ready_o == 4'b0 && waitc < 50) begin
            @(negedge clk); #1;
            waitc++;
        end
        check("grant_wait", waitc, 0);
        check("grant", {28'h0, req_ready_o}, 32'd1 << exp_g);
        @(posedge clk); #1;
        check("ready_pulse", {28'h0, req_ready_o}, 32'h0);
        if (!keep) req_valid_i[exp_g] = 1'b0;
        req_data_i = ~req_data_i;
        b = 0; n = 0; holes = 0; cyc = 0;
        while (b < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (b == stall_b && n < stall_n) begin
                byte_ready_i = 1'b0;
                check("stall_valid", {31'h0, byte_valid_o}, 32'h1);
                check("stall_data", {24'h0, byte_data_o}, {24'h0, exp_b[b]});
                n++;
            end else begin
                byte_ready_i = 1'b1;
                if (byte_valid_o) begin
                    check($sformatf("byte%0d", b), {24'h0, byte_data_o}, {24'h0, exp_b[b]});
                    b++;
                end else begin
                    holes++;
                end
            end
        end
        check("bytes_done", b, 6);
        check("holes", holes, 0);
        @(negedge clk);
        exp_frames = exp_frames + 16'd1;
        check("frames", {16'h0, frames_sent_o}, {16'h0, exp_frames});
        gap = 0;
        while (busy_o && !byte_valid_o && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        check("gap", gap, exp_gap);
        check("busy_idle", {31'h0, busy_o}, 32'h0);
    endtask

    localparam logic [127:0] D4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] DF = {32'h00000001, 32'h40490FDB, 32'hBF800000, 32'h7F800000};

    initial begin
        rst_i = 1'b0; req_valid_i = '0; req_data_i = '0; byte_ready_i = 1'b1; sel = 1'b0;
        exp_frames = '0;

        vecs[0]  = '{1'b1, 4'b0001, {96'h0, 32'h3F800000}, 1'b0, -1, 0, 0, 32'h3F800000};
        vecs[1]  = '{1'b1, 4'b1111, D4, 1'b1, -1, 0, 0, 32'h11111111};
        vecs[2]  = '{1'b0, 4'b1111, D4, 1'b1, -1, 0, 1, 32'h22222222};
        vecs[3]  = '{1'b0, 4'b1111, D4, 1'b1, -1, 0, 2, 32'h33333333};
        vecs[4]  = '{1'b0, 4'b1111, D4, 1'b1, -1, 0, 3, 32'h44444444};
        vecs[5]  = '{1'b0, 4'b1111, D4, 1'b1, -1, 0, 0, 32'h11111111};
        vecs[6]  = '{1'b0, 4'b1010, DF, 1'b0, -1, 0, 1, 32'hBF800000};
        vecs[7]  = '{1'b0, 4'b1010, DF, 1'b0, -1, 0, 3, 32'h00000001};
        vecs[8]  = '{1'b0, 4'b0101, DF, 1'b0, -1, 0, 0, 32'h7F800000};
        vecs[9]  = '{1'b0, 4'b0100, DF, 1'b0,  1, 5, 2, 32'h40490FDB};
        vecs[10] = '{1'b0, 4'b1111, DF, 1'b0, -1, 0, 3, 32'h00000001};

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].rst_before) do_reset();
            run_frame(vecs[v].valid, vecs[v].data, vecs[v].keep, vecs[v].stall_b,
                      vecs[v].stall_n, vecs[v].exp_g, vecs[v].exp_word, 16);
        end

        // Reset while the frame is in DATA k=2 aborts it.
        req_valid_i = 4'b0001;
        req_data_i  = {96'h0, 32'hDEADBEEF};
        #1;
        check("h2_grant", {28'h0, req_ready_o}, 32'h1);
        @(posedge clk); #1;
        req_valid_i = '0;
        repeat (5) @(negedge clk);
        check("h2_k2_byte", {24'h0, byte_data_o}, 32'hAD);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("h2_valid", {31'h0, byte_valid_o}, 32'h0);
        check("h2_frames", {16'h0, frames_sent_o}, 32'h0);
        check("h2_busy", {31'h0, busy_o}, 32'h0);
        exp_frames = '0;
        run_frame(4'b0010, {64'h0, 32'h12345678, 32'h0}, 1'b0, -1, 0, 1, 32'h12345678, 16);

        // No-gap instance: back-to-back frames, word changed in each grant cycle.
        sel = 1'b1;
        do_reset();
        run_frame(4'b0010, {64'h0, 32'h3F800000, 32'h0}, 1'b1, -1, 0, 1, 32'h3F800000, 0);
        run_frame(4'b0010, {64'h0, 32'h40000000, 32'h0}, 1'b1, -1, 0, 1, 32'h40000000, 0);
        run_frame(4'b0010, {64'h0, 32'hC0400000, 32'h0}, 1'b1, -1, 0, 1, 32'hC0400000, 0);
        req_valid_i = '0;

        // Preload the frame counter to its maximum and send one more frame.
        @(negedge clk);
        force u_dut_g0.frames_sent_q = 16'hFFFF;
        @(negedge clk);
        release u_dut_g0.frames_sent_q;
        #1;
        check("preload", {16'h0, frames_sent_o}, 32'h0000FFFF);
        exp_frames = 16'hFFFF;
        run_frame(4'b0001, {96'h0, 32'h3F800000}, 1'b0, -1, 0, 0, 32'h3F800000, 0);
        check("wrap", {16'h0, frames_sent_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fp32_tx_scheduler.md
Name: fp32_tx_scheduler

Overview:
- Shares a single byte-wide UART transmitter between NUM_REQ producers of FP32 words.
- Arbitrates between producers round-robin and captures the granted word.
- Emits each word as a 6-byte frame to the UART byte interface: SYNC, ID, then data bytes B0..B3, LSB first.
- Sits between the FP32 compute datapath and the UART TX serializer; enforces an optional idle gap between frames.

Parameters:
- NUM_REQ, 4, number of requesters (1..4; ID fits in 2 bits).
- SYNC_BYTE, 8'hA5, first byte of every frame.
- GAP_CYCLES, 16, clk_i cycles of idle after a frame before the next grant (0 = no gap).

Ports:
- clk_i  input  1  system clock (50 MHz).
- rst_i  input  1  synchronous reset, active-high.
- req_valid_i  input  NUM_REQ  bit n: requester n holds a word.
- req_data_i  input  32*NUM_REQ  word n in bits [32n+31:32n].
- req_ready_o  output  NUM_REQ  one-hot, single-cycle accept pulse.
- byte_valid_o  output  1  byte_data_o is valid for the UART.
- byte_data_o  output  8  byte to transmit.
- byte_ready_i  input  1  UART accepts the byte this cycle.
- busy_o  output  1  high in any state other than IDLE.
- frames_sent_o  output  16  count of completed frames; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: synchronous, active-high. At the clock edge with rst_i=1:
  - State returns to IDLE.
  - All outputs return to 0: req_ready_o, byte_valid_o, byte_data_o, busy_o, frames_sent_o.
  - Round-robin pointer set to NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame aborts the frame: no further bytes are sent, frames_sent_o is cleared, and the captured word is discarded.
- States: IDLE, SYNC, ID, DATA (2-bit byte index k=0..3), GAP.
- IDLE:
  - If any req_valid_i is set, grant the first set bit searching from pointer+1 upward, modulo NUM_REQ.
  - In that same cycle: req_ready_o[g]=1, capture word and ID, pointer<=g, next state SYNC.
  - If no req_valid_i is set, stay in IDLE.
  - req_ready_o is combinational from req_valid_i in IDLE, so the requester sees valid&ready in one cycle.
- SYNC: byte_valid_o=1, byte_data_o=SYNC_BYTE. On byte_ready_i go to ID.
- ID: byte_data_o={6'b0,id}. On byte_ready_i go to DATA with k=0.
- DATA:
  - byte_data_o = word[8k+7:8k].
  - On byte_ready_i: if k<3 then k<=k+1; if k==3 then frames_sent_o+1 and go to GAP, or to IDLE when GAP_CYCLES=0.
- Output handshake:
  - byte_valid_o stays high, and byte_data_o stays stable, until byte_ready_i is seen.
  - byte_valid_o is never deasserted mid-frame while ready is low.
  - byte_ready_i while byte_valid_o=0 is ignored.
- Latency: grant in cycle t means byte_valid_o=1 with SYNC_BYTE at t+1. With byte_ready_i tied high, the frame occupies cycles t+1..t+6.
- GAP:
  - Counter loads GAP_CYCLES-1 on entry and decrements; go to IDLE when it reaches 0.
  - byte_valid_o=0 throughout. Requests arriving during GAP wait and are not accepted.
- Requester contract: req_data_i only needs to be valid in the grant cycle. Later changes to a requester's data do not affect the frame in flight.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 frames.
- Simultaneous events:
  - The final-byte accept and frames_sent_o increment occur on the same edge.
  - A request made in the same cycle the FSM returns to IDLE is granted on the next cycle (IDLE evaluation).
- busy_o is registered and equals (state != IDLE).

Test Plan:
- Reset, then req_valid_i=4'b0001 with word0=32'h3F800000 (1.0f) and byte_ready_i=1 -> req_ready_o=4'b0001 for one cycle; bytes A5,00,00,00,80,3F on consecutive cycles; frames_sent_o=1; busy_o low after GAP (16 cycles).
- All four requesters valid, words 32'h11111111..44444444 -> grant order 0,1,2,3,0; ID bytes 00,01,02,03,00; each frame separated by exactly 16 idle cycles.
- Backpressure: byte_ready_i low for 5 cycles during the ID byte of the frame for requester 2 -> byte_valid_o stays 1 and byte_data_o stays 8'h02 throughout; the frame then resumes intact.
- rst_i pulsed while in DATA k=2 -> next cycle byte_valid_o=0, frames_sent_o=0, busy_o=0; the following request starts a fresh frame with A5.
- GAP_CYCLES=0, requester 1 held valid continuously -> 6 bytes per frame back-to-back with exactly one IDLE cycle between frames; the word change in the grant cycle is captured.
- Preload frames_sent_o to 16'hFFFF via 65535 frames (or force) -> the next frame wraps frames_sent_o to 16'h0000.
